// File: rtl/halfword_pkg.sv
// Shared types and helpers for the byte-to-halfword packer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package halfword_pkg;

    // Packing FSM: waiting for the low (first) byte, or holding it and waiting for the second.
    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } hw_state_t;

    // Fill byte used when a stream ends on an odd byte.
    localparam logic [7:0] HW_PAD_DEFAULT = 8'h00;

    // Combine the first byte (lo) and second byte (hi) of a pair into one halfword.
    // Little-endian puts the first byte in [7:0]; big-endian puts it in [15:8].
    function automatic logic [15:0] hw_pack(input logic [7:0] lo,
                                            input logic [7:0] hi,
                                            input bit         big_endian);
        logic [15:0] w_word;
        if (big_endian) begin
            w_word = {lo, hi};
        end else begin
            w_word = {hi, lo};
        end
        return w_word;
    endfunction

endpackage

// File: rtl/halfword_packer.sv
// Packs a valid/ready byte stream into 16-bit halfwords on a registered valid/ready output.
// Latency: a word appears on data the cycle after its completing byte is accepted.
// Backpressure: in_ready = output slot free (empty or being drained) and not in reset; 1 byte/cycle sustained.
module halfword_packer
    import halfword_pkg::*;
#(
    parameter bit         BIG_ENDIAN = 1'b0,
    parameter logic [7:0] PAD_BYTE   = HW_PAD_DEFAULT,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic [15:0]      data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             data_last,
    output logic [CNT_W-1:0] word_count
);

    hw_state_t        r_state;
    logic [7:0]       r_lo;
    logic [15:0]      r_data;
    logic             r_data_valid;
    logic             r_data_last;
    logic [CNT_W-1:0] r_word_count;

    logic             w_out_free;
    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_load;
    logic [15:0]      w_load_word;
    logic             w_load_last;

    // The slot can take a new word when it is empty or its current word leaves this cycle.
    // Depends only on registered state, data_ready and reset: no path from the input byte side.
    assign w_out_free = !r_data_valid || data_ready;
    assign in_ready   = w_out_free && !reset;
    assign w_in_acc   = in_valid && in_ready;
    assign w_out_acc  = data_valid && data_ready;

    // A word completes either on the second byte of a pair or on an odd trailing byte.
    assign w_load      = w_in_acc && ((r_state == S_HI) || in_last);
    assign w_load_word = (r_state == S_HI) ? hw_pack(r_lo, in_byte, BIG_ENDIAN)
                                           : hw_pack(in_byte, PAD_BYTE, BIG_ENDIAN);
    assign w_load_last = (r_state == S_HI) ? in_last : 1'b1;

    // Outputs are forced low while reset is high so the rise cycle already reads zero,
    // before the registers themselves clear on the next edge.
    assign data       = reset ? 16'h0 : r_data;
    assign data_valid = reset ? 1'b0  : r_data_valid;
    assign data_last  = reset ? 1'b0  : r_data_last;
    assign word_count = r_word_count;

    // Packing FSM, output slot and accepted-word counter; reset discards any partial or pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_LO;
            r_lo         <= 8'h00;
            r_data       <= 16'h0000;
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_in_acc) begin
                case (r_state)
                    S_LO: begin
                        if (!in_last) begin
                            r_lo    <= in_byte;
                            r_state <= S_HI;
                        end
                    end
                    S_HI: begin
                        r_state <= S_LO;
                    end
                    default: begin
                        r_state <= S_LO;
                    end
                endcase
            end

            // A load overrides a drain in the same cycle so back-to-back words have no bubble.
            if (w_load) begin
                r_data       <= w_load_word;
                r_data_last  <= w_load_last;
                r_data_valid <= 1'b1;
            end else if (w_out_acc) begin
                r_data_valid <= 1'b0;
            end

            if (w_out_acc) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end
        end
    end

endmodule
